pipe_stall_ctrl: RTL and testbench

//  Hazard/stall sequencer for the 5-stage pipeline. Sits beside the ID stage.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_stall_ctrl_mdu_busy_timer.sv | 64 ++++++
 rtl/pipe_stall_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared constants and types for the pipeline stall sequencer
//                and the multiply/divide unit busy timer.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // MDU busy-timer states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    // Architectural zero register: writes to it never create a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default MDU latencies, shared with the MDU datapath
    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_DIV_LAT = 33;
    localparam int DEF_CNT_W   = 6;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_mdu_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_busy_timer
//  Description : Tracks an in-flight multiply/divide operation. A start pulse
//                loads the down-counter with the operation latency; busy stays
//                high until the counter has expired.
//  Ports       : clk, rst_n      clock / async active-low reset
//                i_start         one-cycle MDU launch pulse
//                i_div           1 = divide latency, 0 = multiply latency
//                o_busy          MDU operation in flight (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] C_MUL_LAT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] C_DIV_LAT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    mdu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    // Single-process FSM; busy is registered alongside the state so it is
    // glitch-free and drops asynchronously with reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (i_start) begin
                r_state <= ST_BUSY;
                r_cnt   <= i_div ? C_DIV_LAT : C_MUL_LAT;
                r_busy  <= 1'b1;
            end
        end else begin
            // The last busy cycle is the one where the count reads 1, so the
            // consumer sees exactly LAT busy cycles after the launch.
            if (r_cnt == C_ONE) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_cnt   <= r_cnt - C_ONE;
            end
        end
    end

    assign o_busy = r_busy;

endmodule : mdu_busy_timer
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Hazard/stall sequencer beside the ID stage of the 5-stage
//                pipeline. Detects load-use and HI/LO (MDU) hazards, holds PC
//                and IF/ID, bubbles ID/EXE, selects the ID redirect target
//                and launches the multi-cycle MDU.
//  Config      : PIPE_STALL_CNT_EN - adds o_stall_cycles, a saturating count
//                of stalled cycles.
//  Ports       : clk, rst_n                  clock / async active-low reset
//                i_id_valid                  ID holds a valid instruction
//                i_id_rs, i_id_rt            ID source registers
//                i_id_use_rs, i_id_use_rt    ID reads rs / rt
//                i_id_md_op, i_id_md_div     ID is MULT/DIV (div selects DIV)
//                i_id_hilo_op                ID is MFHI/MFLO/MTHI/MTLO
//                i_id_redirect               ID resolved a taken control flow
//                i_exe_is_load, i_exe_waddr  EXE load and its destination
//                o_pc_stall, o_ifid_stall    hold PC / IF/ID
//                o_idexe_bubble              load NOP into ID/EXE
//                o_if_pc_sel                 1 = next PC is id_pc
//                o_mdu_start, o_mdu_busy     MDU launch pulse / in flight
//                o_stall_cycles              stall counter (config only)
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_id_valid,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_use_rs,
    input  logic        i_id_use_rt,
    input  logic        i_id_md_op,
    input  logic        i_id_md_div,
    input  logic        i_id_hilo_op,
    input  logic        i_id_redirect,
    input  logic        i_exe_is_load,
    input  logic [4:0]  i_exe_waddr,
    output logic        o_pc_stall,
    output logic        o_ifid_stall,
    output logic        o_idexe_bubble,
    output logic        o_if_pc_sel,
    output logic        o_mdu_start,
`ifdef PIPE_STALL_CNT_EN
    output logic [31:0] o_stall_cycles,
`endif
    output logic        o_mdu_busy
);

    logic w_valid;
    logic w_load_use;
    logic w_md_haz;
    logic w_stall;
    logic w_mdu_start;
    logic w_mdu_busy;

    // Outputs must be quiet while reset is held even if ID/EXE inputs are
    // still presenting a hazard, so the valid qualifier includes rst_n.
    assign w_valid = i_id_valid & rst_n;

    assign w_load_use = w_valid & i_exe_is_load & (i_exe_waddr != REG_ZERO) &
                        ((i_id_use_rs & (i_id_rs == i_exe_waddr)) |
                         (i_id_use_rt & (i_id_rt == i_exe_waddr)));

    assign w_md_haz = w_valid & w_mdu_busy & (i_id_md_op | i_id_hilo_op);

    assign w_stall     = w_load_use | w_md_haz;
    assign w_mdu_start = w_valid & i_id_md_op & ~w_stall;

    assign o_pc_stall     = w_stall;
    assign o_ifid_stall   = w_stall;
    assign o_idexe_bubble = w_stall;
    // A stalled redirect keeps ID held, so it is simply re-evaluated later.
    assign o_if_pc_sel    = w_valid & i_id_redirect & ~w_stall;
    assign o_mdu_start    = w_mdu_start;
    assign o_mdu_busy     = w_mdu_busy;

    mdu_busy_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_mdu_busy_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mdu_start),
        .i_div   (i_id_md_div),
        .o_busy  (w_mdu_busy)
    );

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Self-checking bench for pipe_stall_ctrl. A reference model
//                tracks the MDU as a "busy until cycle N" timestamp and checks
//                every output each cycle, plus directed hazard scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int C_MUL_LAT = 4;
    localparam int C_DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, exe_waddr = '0;
    logic        id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic        id_md_op = 1'b0, id_md_div = 1'b0, id_hilo_op = 1'b0;
    logic        id_redirect = 1'b0, exe_is_load = 1'b0;
    logic        pc_stall, ifid_stall, idexe_bubble, if_pc_sel, mdu_start, mdu_busy;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // reference-model state
    longint cyc      = 0;
    longint busy_end = 0;    // MDU busy while cyc < busy_end
    longint stall_ref = 0;

    // samples captured at the last check point
    logic s_stall, s_sel, s_start, s_busy;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MUL_LAT(C_MUL_LAT), .DIV_LAT(C_DIV_LAT), .CNT_W(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_id_valid     (id_valid),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_use_rs    (id_use_rs),
        .i_id_use_rt    (id_use_rt),
        .i_id_md_op     (id_md_op),
        .i_id_md_div    (id_md_div),
        .i_id_hilo_op   (id_hilo_op),
        .i_id_redirect  (id_redirect),
        .i_exe_is_load  (exe_is_load),
        .i_exe_waddr    (exe_waddr),
        .o_pc_stall     (pc_stall),
        .o_ifid_stall   (ifid_stall),
        .o_idexe_bubble (idexe_bubble),
        .o_if_pc_sel    (if_pc_sel),
        .o_mdu_start    (mdu_start),
`ifdef PIPE_STALL_CNT_EN
        .o_stall_cycles (stall_cycles),
`endif
        .o_mdu_busy     (mdu_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic md, input logic dv,
                         input logic hl, input logic rd, input logic ld, input logic [4:0] wa);
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;
        id_md_op = md; id_md_div = dv; id_hilo_op = hl; id_redirect = rd;
        exe_is_load = ld; exe_waddr = wa;
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    // Check one cycle against the model, then advance across the clock edge.
    task automatic cycle_chk();
        logic lu, busy_e, md_e, stall_e, sel_e, start_e;
        @(negedge clk);
        busy_e  = (cyc < busy_end);
        lu      = id_valid && exe_is_load && (exe_waddr != 5'd0) &&
                  ((id_use_rs && id_rs == exe_waddr) || (id_use_rt && id_rt == exe_waddr));
        md_e    = id_valid && busy_e && (id_md_op || id_hilo_op);
        stall_e = lu || md_e;
        sel_e   = id_valid && id_redirect && !stall_e;
        start_e = id_valid && id_md_op && !stall_e;
        chk("pc_stall",     {31'd0, pc_stall},     {31'd0, stall_e});
        chk("ifid_stall",   {31'd0, ifid_stall},   {31'd0, stall_e});
        chk("idexe_bubble", {31'd0, idexe_bubble}, {31'd0, stall_e});
        chk("if_pc_sel",    {31'd0, if_pc_sel},    {31'd0, sel_e});
        chk("mdu_start",    {31'd0, mdu_start},    {31'd0, start_e});
        chk("mdu_busy",     {31'd0, mdu_busy},     {31'd0, busy_e});
`ifdef PIPE_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, stall_ref[31:0]);
`endif
        s_stall = pc_stall; s_sel = if_pc_sel; s_start = mdu_start; s_busy = mdu_busy;
        if (start_e) busy_end = cyc + 1 + (id_md_div ? C_DIV_LAT : C_MUL_LAT);
        if (stall_e) stall_ref++;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        int n;
        // ---- reset: outputs quiet even with a hazard presented ----
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pc_stall",  {31'd0, pc_stall},  32'd0);
        chk("rst_if_pc_sel", {31'd0, if_pc_sel}, 32'd0);
        chk("rst_mdu_start", {31'd0, mdu_start}, 32'd0);
        chk("rst_mdu_busy",  {31'd0, mdu_busy},  32'd0);
        idle_in();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- 1: load-use on rs, one stall then release ----
        drive(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
        cycle_chk();
        chk("t1_stall", {31'd0, s_stall}, 32'd1);
        drive(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
        cycle_chk();
        chk("t1_release", {31'd0, s_stall}, 32'd0);

        // ---- 2: load to $0 never creates a dependency ----
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        cycle_chk();
        chk("t2_zero_reg", {31'd0, s_stall}, 32'd0);

        // ---- 3: DIV then MFLO stalls DIV_LAT cycles ----
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle_chk();
        chk("t3_start", {31'd0, s_start}, 32'd1);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle_chk();
            if (!s_stall) break;
            n++;
        end
        chk("t3_div_stall_len", n, C_DIV_LAT);

        // ---- 4: MULT, ADD (free), MFHI released 4 cycles after start ----
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle_chk();
        drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle_chk();
        chk("t4_add_free", {31'd0, s_stall}, 32'd0);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle_chk();
            if (!s_stall) break;
            n++;
        end
        chk("t4_mul_stall_len", n, C_MUL_LAT - 1);

        // ---- 5: taken branch under load-use: held, then redirect ----
        drive(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7);
        cycle_chk();
        chk("t5_sel_stalled", {31'd0, s_sel}, 32'd0);
        drive(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        cycle_chk();
        chk("t5_sel_taken", {31'd0, s_sel}, 32'd1);

        // ---- 6: reset mid-DIV aborts the count ----
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle_chk();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        repeat (23) cycle_chk();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_busy", {31'd0, mdu_busy}, 32'd0);
        chk("t6_async_stall", {31'd0, pc_stall}, 32'd0);
`ifdef PIPE_STALL_CNT_EN
        chk("t6_cnt_clear", stall_cycles, 32'd0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        busy_end = 0;
        stall_ref = 0;
        @(posedge clk); cyc++; #1;
        cycle_chk();
        chk("t6_mflo_free", {31'd0, s_stall}, 32'd0);
        chk("t6_no_restart", {31'd0, s_start}, 32'd0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), 1'($urandom), 5'($urandom_range(0, 3)));
            cycle_chk();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pipe_stall_ctrl
`default_nettype wire
